rename_dispatch: RTL and testbench

- Dual-issue rename/dispatch stage directly upstream of the reorder buffer.
- Accepts an instruction pair per handshake and allocates two consecutive ROB tags.
- Renames sources through an 8-entry alias map and drives the ROB's new-instruction interface for one cycle.
- Snoops the ROB commit bus to update its architectural register file and clear stale mappings; on an exception flush it discards all speculative mappings.

---
 rtl/rename_dispatch.sv | 208 ++++++++++++++++++++
 tb/tb_rename_dispatch.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_dispatch.sv
// Dual-issue rename/dispatch stage: allocates ROB tag pairs, renames sources
// through an alias map and tracks architectural state from the ROB commit bus.
module rename_dispatch #(
  parameter int NUM_AREGS = 8,
  parameter int ROB_DEPTH = 8,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mul_a,
  input  logic              in_mul_b,
  input  logic [2:0]        in_rd_a,
  input  logic [2:0]        in_rs1_a,
  input  logic [2:0]        in_rs2_a,
  input  logic [2:0]        in_rd_b,
  input  logic [2:0]        in_rs1_b,
  input  logic [2:0]        in_rs2_b,
  output logic              rat_new_instr,
  output logic              new_mul_a,
  output logic              new_mul_b,
  output logic [2:0]        rd_a,
  output logic [2:0]        rd_b,
  output logic [2:0]        tag_a,
  output logic [2:0]        tag_b,
  output logic [2:0]        src1a,
  output logic [2:0]        src2a,
  output logic [2:0]        src1b,
  output logic [2:0]        src2b,
  output logic              src1a_valid,
  output logic              src2a_valid,
  output logic              src1b_valid,
  output logic              src2b_valid,
  output logic [DATA_W-1:0] src1a_val,
  output logic [DATA_W-1:0] src2a_val,
  output logic [DATA_W-1:0] src1b_val,
  output logic [DATA_W-1:0] src2b_val,
  input  logic              rob_bus_trigger,
  input  logic              rob_exception_flush,
  input  logic [2:0]        rob_bus_tag,
  input  logic [DATA_W-1:0] rob_bus_value,
  output logic [3:0]        occupancy
);

  localparam int AW = $clog2(NUM_AREGS);
  localparam int TW = $clog2(ROB_DEPTH);

  typedef struct packed {
    logic              valid;
    logic [TW-1:0]     tag;
    logic [DATA_W-1:0] val;
  } src_t;

  logic [TW-1:0]                 alloc_ptr_q, alloc_ptr_d;
  logic [3:0]                    occ_q, occ_d;
  logic [NUM_AREGS-1:0]          map_busy_q, map_busy_d;
  logic [NUM_AREGS-1:0][TW-1:0]  map_tag_q, map_tag_d;
  logic [NUM_AREGS-1:0][DATA_W-1:0] arf_q, arf_d;
  logic [ROB_DEPTH-1:0][AW-1:0]  tag_dest_q, tag_dest_d;

  logic              rat_q, rat_d;
  logic              mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [AW-1:0]     rd_a_q, rd_a_d, rd_b_q, rd_b_d;
  logic [TW-1:0]     tag_a_q, tag_a_d, tag_b_q, tag_b_d;
  src_t [3:0]        src_q, src_d;

  logic              flush, commit, accept;
  logic [TW-1:0]     new_tag_a, new_tag_b;
  logic [AW-1:0]     commit_dest;

  // Rules 2-4 of source resolution; the intra-pair check is applied by the caller.
  function automatic src_t resolve_src(input logic [AW-1:0] r);
    src_t s;
    s = '0;
    if (map_busy_q[r] && commit && (map_tag_q[r] == rob_bus_tag)) begin
      s.valid = 1'b1;
      s.tag   = map_tag_q[r];
      s.val   = rob_bus_value;
    end else if (map_busy_q[r]) begin
      s.tag   = map_tag_q[r];
    end else begin
      s.valid = 1'b1;
      s.val   = (commit && (commit_dest == r)) ? rob_bus_value : arf_q[r];
    end
    return s;
  endfunction

  always_comb begin
    flush       = rob_bus_trigger && rob_exception_flush;
    commit      = rob_bus_trigger && !rob_exception_flush;
    in_ready    = !reset && (occ_q <= 4'(ROB_DEPTH - 2)) && !flush;
    accept      = in_valid && in_ready;
    new_tag_a   = alloc_ptr_q;
    new_tag_b   = alloc_ptr_q + TW'(1);
    commit_dest = tag_dest_q[rob_bus_tag];
  end

  always_comb begin
    alloc_ptr_d = alloc_ptr_q;
    occ_d       = occ_q;
    map_busy_d  = map_busy_q;
    map_tag_d   = map_tag_q;
    arf_d       = arf_q;
    tag_dest_d  = tag_dest_q;
    rat_d       = accept;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    rd_a_d      = rd_a_q;
    rd_b_d      = rd_b_q;
    tag_a_d     = tag_a_q;
    tag_b_d     = tag_b_q;
    src_d       = src_q;

    if (accept) begin
      mul_a_d  = in_mul_a;
      mul_b_d  = in_mul_b;
      rd_a_d   = in_rd_a;
      rd_b_d   = in_rd_b;
      tag_a_d  = new_tag_a;
      tag_b_d  = new_tag_b;
      src_d[0] = resolve_src(in_rs1_a);
      src_d[1] = resolve_src(in_rs2_a);
      src_d[2] = (in_rs1_b == in_rd_a) ? src_t'{1'b0, new_tag_a, '0} : resolve_src(in_rs1_b);
      src_d[3] = (in_rs2_b == in_rd_a) ? src_t'{1'b0, new_tag_a, '0} : resolve_src(in_rs2_b);
    end

    if (commit) begin
      arf_d[commit_dest] = rob_bus_value;
      if (map_busy_q[commit_dest] && (map_tag_q[commit_dest] == rob_bus_tag))
        map_busy_d[commit_dest] = 1'b0;
    end

    // Dispatch writes come after the commit clear so a new mapping survives it.
    if (accept) begin
      map_busy_d[in_rd_a]   = 1'b1;
      map_tag_d[in_rd_a]    = new_tag_a;
      map_busy_d[in_rd_b]   = 1'b1;
      map_tag_d[in_rd_b]    = new_tag_b;
      tag_dest_d[new_tag_a] = in_rd_a;
      tag_dest_d[new_tag_b] = in_rd_b;
      alloc_ptr_d           = alloc_ptr_q + TW'(2);
    end

    if (flush) begin
      occ_d      = '0;
      map_busy_d = '0;
    end else begin
      occ_d = occ_q + (accept ? 4'd2 : 4'd0) - ((commit && (occ_q != 4'd0)) ? 4'd1 : 4'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alloc_ptr_q <= '0;
      occ_q       <= '0;
      map_busy_q  <= '0;
      map_tag_q   <= '0;
      arf_q       <= '0;
      tag_dest_q  <= '0;
      rat_q       <= 1'b0;
      mul_a_q     <= 1'b0;
      mul_b_q     <= 1'b0;
      rd_a_q      <= '0;
      rd_b_q      <= '0;
      tag_a_q     <= '0;
      tag_b_q     <= '0;
      src_q       <= '0;
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      occ_q       <= occ_d;
      map_busy_q  <= map_busy_d;
      map_tag_q   <= map_tag_d;
      arf_q       <= arf_d;
      tag_dest_q  <= tag_dest_d;
      rat_q       <= rat_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      rd_a_q      <= rd_a_d;
      rd_b_q      <= rd_b_d;
      tag_a_q     <= tag_a_d;
      tag_b_q     <= tag_b_d;
      src_q       <= src_d;
    end
  end

  assign rat_new_instr = rat_q;
  assign new_mul_a     = mul_a_q;
  assign new_mul_b     = mul_b_q;
  assign rd_a          = rd_a_q;
  assign rd_b          = rd_b_q;
  assign tag_a         = tag_a_q;
  assign tag_b         = tag_b_q;
  assign src1a         = src_q[0].tag;
  assign src2a         = src_q[1].tag;
  assign src1b         = src_q[2].tag;
  assign src2b         = src_q[3].tag;
  assign src1a_valid   = src_q[0].valid;
  assign src2a_valid   = src_q[1].valid;
  assign src1b_valid   = src_q[2].valid;
  assign src2b_valid   = src_q[3].valid;
  assign src1a_val     = src_q[0].val;
  assign src2a_val     = src_q[1].val;
  assign src1b_val     = src_q[2].val;
  assign src2b_val     = src_q[3].val;
  assign occupancy     = occ_q;

endmodule

// File: tb/tb_rename_dispatch.sv
// Bench for rename_dispatch: directed scenarios plus random traffic, all
// compared against a behavioural rename/ARF model kept in this module.
module tb_rename_dispatch;

  logic        clk;
  logic        reset;
  logic        in_valid, in_ready, in_mul_a, in_mul_b;
  logic [2:0]  in_rd_a, in_rs1_a, in_rs2_a, in_rd_b, in_rs1_b, in_rs2_b;
  logic        rat_new_instr, new_mul_a, new_mul_b;
  logic [2:0]  rd_a, rd_b, tag_a, tag_b, src1a, src2a, src1b, src2b;
  logic        src1a_valid, src2a_valid, src1b_valid, src2b_valid;
  logic [31:0] src1a_val, src2a_val, src1b_val, src2b_val;
  logic        rob_bus_trigger, rob_exception_flush;
  logic [2:0]  rob_bus_tag;
  logic [31:0] rob_bus_value;
  logic [3:0]  occupancy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_arf[8];
  bit          m_busy[8];
  int          m_mtag[8];
  int          m_tdest[8];
  int          m_alloc, m_occ;

  // Expected dispatch outputs
  bit          e_rat, e_mul_a, e_mul_b;
  int          e_rd_a, e_rd_b, e_tag_a, e_tag_b;
  int          e_tag[4];
  bit          e_v[4];
  logic [31:0] e_val[4];

  rename_dispatch dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_mul_a(in_mul_a), .in_mul_b(in_mul_b),
    .in_rd_a(in_rd_a), .in_rs1_a(in_rs1_a), .in_rs2_a(in_rs2_a),
    .in_rd_b(in_rd_b), .in_rs1_b(in_rs1_b), .in_rs2_b(in_rs2_b),
    .rat_new_instr(rat_new_instr), .new_mul_a(new_mul_a), .new_mul_b(new_mul_b),
    .rd_a(rd_a), .rd_b(rd_b), .tag_a(tag_a), .tag_b(tag_b),
    .src1a(src1a), .src2a(src2a), .src1b(src1b), .src2b(src2b),
    .src1a_valid(src1a_valid), .src2a_valid(src2a_valid),
    .src1b_valid(src1b_valid), .src2b_valid(src2b_valid),
    .src1a_val(src1a_val), .src2a_val(src2a_val),
    .src1b_val(src1b_val), .src2b_val(src2b_val),
    .rob_bus_trigger(rob_bus_trigger), .rob_exception_flush(rob_exception_flush),
    .rob_bus_tag(rob_bus_tag), .rob_bus_value(rob_bus_value),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void refSource(input int r, output int t, output bit v, output logic [31:0] x);
    bit com;
    com = rob_bus_trigger && !rob_exception_flush;
    if (m_busy[r] && com && m_mtag[r] == int'(rob_bus_tag)) begin
      t = m_mtag[r]; v = 1; x = rob_bus_value;
    end else if (m_busy[r]) begin
      t = m_mtag[r]; v = 0; x = 0;
    end else begin
      t = 0; v = 1;
      x = (com && m_tdest[rob_bus_tag] == r) ? rob_bus_value : m_arf[r];
    end
  endfunction

  task automatic setPair(input bit v, input bit ma, input bit mb, input int rda, input int r1a,
                         input int r2a, input int rdb, input int r1b, input int r2b);
    in_valid = v; in_mul_a = ma; in_mul_b = mb;
    in_rd_a = 3'(rda); in_rs1_a = 3'(r1a); in_rs2_a = 3'(r2a);
    in_rd_b = 3'(rdb); in_rs1_b = 3'(r1b); in_rs2_b = 3'(r2b);
  endtask

  task automatic setBus(input bit t, input bit f, input int tg, input logic [31:0] vl);
    rob_bus_trigger = t; rob_exception_flush = f; rob_bus_tag = 3'(tg); rob_bus_value = vl;
  endtask

  // One clock: check in_ready, advance the model with the driven inputs, then check outputs.
  task automatic applyStimulus();
    bit flush, com, ready, acc;
    int srcs[4];
    logic [2:0]  g_tag[4];
    logic        g_v[4];
    logic [31:0] g_val[4];
    #1;
    flush = rob_bus_trigger && rob_exception_flush;
    com   = rob_bus_trigger && !rob_exception_flush;
    ready = !reset && m_occ <= 6 && !flush;
    acc   = in_valid && ready;
    checkOutput("in_ready", in_ready, ready);
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        m_arf[i] = 0; m_busy[i] = 0; m_mtag[i] = 0; m_tdest[i] = 0;
      end
      m_alloc = 0; m_occ = 0;
      e_rat = 0; e_mul_a = 0; e_mul_b = 0; e_rd_a = 0; e_rd_b = 0; e_tag_a = 0; e_tag_b = 0;
      for (int i = 0; i < 4; i++) begin e_tag[i] = 0; e_v[i] = 0; e_val[i] = 0; end
    end else begin
      e_rat = acc;
      if (acc) begin
        e_mul_a = in_mul_a; e_mul_b = in_mul_b;
        e_rd_a = in_rd_a; e_rd_b = in_rd_b;
        e_tag_a = m_alloc; e_tag_b = (m_alloc + 1) % 8;
        srcs = '{int'(in_rs1_a), int'(in_rs2_a), int'(in_rs1_b), int'(in_rs2_b)};
        for (int i = 0; i < 4; i++) begin
          if (i >= 2 && srcs[i] == int'(in_rd_a)) begin
            e_tag[i] = e_tag_a; e_v[i] = 0; e_val[i] = 0;
          end else begin
            refSource(srcs[i], e_tag[i], e_v[i], e_val[i]);
          end
        end
      end
      if (com) begin
        int d;
        d = m_tdest[rob_bus_tag];
        m_arf[d] = rob_bus_value;
        if (m_busy[d] && m_mtag[d] == int'(rob_bus_tag)) m_busy[d] = 0;
      end
      if (acc) begin
        m_busy[in_rd_a] = 1; m_mtag[in_rd_a] = e_tag_a;
        m_busy[in_rd_b] = 1; m_mtag[in_rd_b] = e_tag_b;
        m_tdest[e_tag_a] = in_rd_a; m_tdest[e_tag_b] = in_rd_b;
        m_alloc = (m_alloc + 2) % 8;
      end
      if (flush) begin
        m_occ = 0;
        for (int i = 0; i < 8; i++) m_busy[i] = 0;
      end else begin
        m_occ = m_occ + (acc ? 2 : 0) - ((com && m_occ > 0) ? 1 : 0);
      end
    end
    @(posedge clk);
    #1;
    checkOutput("rat_new_instr", rat_new_instr, e_rat);
    checkOutput("occupancy", occupancy, m_occ);
    checkOutput("new_mul_a", new_mul_a, e_mul_a);
    checkOutput("new_mul_b", new_mul_b, e_mul_b);
    checkOutput("rd_a", rd_a, e_rd_a);
    checkOutput("rd_b", rd_b, e_rd_b);
    checkOutput("tag_a", tag_a, e_tag_a);
    checkOutput("tag_b", tag_b, e_tag_b);
    g_tag = '{src1a, src2a, src1b, src2b};
    g_v   = '{src1a_valid, src2a_valid, src1b_valid, src2b_valid};
    g_val = '{src1a_val, src2a_val, src1b_val, src2b_val};
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("src%0d_valid", i), g_v[i], e_v[i]);
      if (e_v[i]) checkOutput($sformatf("src%0d_val", i), g_val[i], e_val[i]);
      else        checkOutput($sformatf("src%0d_tag", i), g_tag[i], e_tag[i]);
    end
  endtask

  task automatic doReset();
    reset = 1;
    setPair(0, 0, 0, 0, 0, 0, 0, 0, 0);
    setBus(0, 0, 0, 0);
    applyStimulus();
    applyStimulus();
    reset = 0;
  endtask

  initial begin
    reset = 1;
    setPair(0, 0, 0, 0, 0, 0, 0, 0, 0);
    setBus(0, 0, 0, 0);
    doReset();

    // Scenario 1: independent pair
    setPair(1, 0, 1, 1, 2, 3, 4, 5, 6); applyStimulus();
    checkOutput("s1_tag_a", tag_a, 0);
    checkOutput("s1_tag_b", tag_b, 1);
    checkOutput("s1_occ", occupancy, 2);
    setPair(0, 0, 0, 0, 0, 0, 0, 0, 0); applyStimulus();
    checkOutput("s1_pulse_end", rat_new_instr, 0);

    // Scenarios 2 and 3: intra-pair dependency, then commit bypass
    doReset();
    setPair(1, 0, 0, 1, 2, 3, 5, 1, 1); applyStimulus();
    checkOutput("s2_src1b_valid", src1b_valid, 0);
    checkOutput("s2_src2b_tag", src2b, 0);
    setPair(1, 0, 0, 2, 1, 0, 6, 5, 1); setBus(1, 0, 0, 32'h55); applyStimulus();
    checkOutput("s3_bypass_val", src1a_val, 32'h55);
    setPair(1, 0, 0, 7, 1, 1, 4, 1, 0); setBus(0, 0, 0, 0); applyStimulus();
    checkOutput("s3_arf_val", src1a_val, 32'h55);

    // Scenario 4: fill, stall, drain two, wrap
    doReset();
    setBus(1, 0, 0, 32'h9); applyStimulus();
    checkOutput("s4_no_underflow", occupancy, 0);
    setBus(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      setPair(1, 1, 0, i, i + 1, i + 2, i + 4, i, i + 3); applyStimulus();
    end
    checkOutput("s4_occ_full", occupancy, 8);
    applyStimulus();
    checkOutput("s4_stalled", rat_new_instr, 0);
    setPair(0, 0, 0, 0, 0, 0, 0, 0, 0);
    setBus(1, 0, 0, 32'h11); applyStimulus();
    setBus(1, 0, 1, 32'h22); applyStimulus();
    setBus(0, 0, 0, 0);
    checkOutput("s4_occ_drained", occupancy, 6);
    setPair(1, 0, 1, 2, 0, 4, 3, 2, 7); applyStimulus();
    checkOutput("s4_wrap_tag_a", tag_a, 0);

    // Scenario 5: flush discards speculative mappings
    doReset();
    setPair(1, 0, 0, 1, 0, 0, 2, 0, 0); applyStimulus();
    setPair(0, 0, 0, 0, 0, 0, 0, 0, 0); setBus(1, 0, 0, 32'h77); applyStimulus();
    setPair(1, 0, 0, 1, 2, 3, 5, 6, 7); setBus(0, 0, 0, 0); applyStimulus();
    setPair(1, 0, 0, 3, 3, 3, 3, 3, 3); setBus(1, 1, 2, 32'hdead); applyStimulus();
    checkOutput("s5_occ_flushed", occupancy, 0);
    setPair(1, 0, 0, 6, 1, 5, 7, 1, 2); setBus(0, 0, 0, 0); applyStimulus();
    checkOutput("s5_old_arf", src1a_val, 32'h77);

    // Scenario 6: same-destination pair
    doReset();
    setPair(1, 0, 0, 3, 1, 2, 3, 3, 1); applyStimulus();
    setPair(0, 0, 0, 0, 0, 0, 0, 0, 0); setBus(1, 0, 0, 32'h9); applyStimulus();
    setPair(1, 0, 0, 4, 3, 0, 5, 0, 3); setBus(0, 0, 0, 0); applyStimulus();
    checkOutput("s6_still_busy", src1a_valid, 0);
    checkOutput("s6_map_tag_b", src1a, 1);

    // Random traffic with mostly in-order commits
    doReset();
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      setPair($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0)
        setBus(1, $urandom_range(0, 59) == 0,
               ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : ((m_alloc - m_occ + 16) % 8),
               $urandom);
      else
        setBus(0, $urandom_range(0, 1), $urandom_range(0, 7), $urandom);
      applyStimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
